div_uns_seq: RTL and testbench

Sequential unsigned divider computing Q = A / Y and R = A mod Y, so that A = Q*Y + R. It uses a radix-2 restoring iteration and produces one quotient bit per cycle. It is the inverse counterpart of the unsigned multiply-add datapath: it recovers quotient and remainder from a product-plus-augend word. It sits behind a valid/ready handshake on both sides so it can share the arithmetic pipeline with the multiply-add blocks.

---
 rtl/div_uns_seq.sv | 160 ++++++++++++++++
 tb/tb_div_uns_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_uns_seq.sv
// rtl/div_uns_seq.sv - sequential radix-2 restoring unsigned divider with valid/ready handshake
//
// Computes Q = A / Y and R = A mod Y, one quotient bit per cycle.
//
// Parameters:
//   widthA  dividend / quotient width (>= widthY, >= 2)
//   widthY  divisor / remainder width
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operands A, Y valid
//   in_ready_o   block accepts operands (registered, IDLE only)
//   A            dividend
//   Y            divisor
//   out_valid_o  Q, R (and DZ) valid (registered)
//   out_ready_i  consumer accepts result
//   Q            quotient
//   R            remainder
//   DZ           divide-by-zero flag (only with DIVUNS_DIV0_FLAG_EN)
//
// Optional feature macro: DIVUNS_DIV0_FLAG_EN
//   When defined, a zero divisor bypasses the iteration and completes one
//   edge after acceptance with DZ=1, Q=all ones, R=A[widthY-1:0].

module div_uns_seq #(
    parameter int widthA = 16,
    parameter int widthY = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [widthA-1:0] A,
    input  logic [widthY-1:0] Y,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [widthA-1:0] Q,
    output logic [widthY-1:0] R
`ifdef DIVUNS_DIV0_FLAG_EN
    ,
    output logic              DZ
`endif
);

    localparam int CW = (widthA > 1) ? $clog2(widthA) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(widthA - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    logic [widthA-1:0] qs;       // quotient / dividend shift register
    logic [widthY-1:0] rem;      // partial remainder between steps
    logic [widthY-1:0] ys;       // captured divisor
    logic [CW-1:0]     cnt;

    logic [widthY:0]   shifted;  // widthY+1-bit partial remainder after the shift
    logic              ge;       // trial subtraction has no borrow
    logic [widthY-1:0] rem_next;
    logic [widthA-1:0] qs_next;

`ifdef DIVUNS_DIV0_FLAG_EN
    logic              dz_pend;  // accepted operation had a zero divisor
`endif

    // The remainder held between steps is always < Y for a non-zero divisor,
    // so only the shifted value needs the extra bit. When the trial succeeds
    // the true difference is < Y, so a widthY-bit modular subtract is exact;
    // with Y=0 it simply passes the low bits through, which yields
    // R = A[widthY-1:0] after the full iteration.
    always_comb begin
        shifted  = {rem, qs[widthA-1]};
        ge       = (shifted >= {1'b0, ys});
        rem_next = ge ? (shifted[widthY-1:0] - ys) : shifted[widthY-1:0];
        qs_next  = {qs[widthA-2:0], ge};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            Q           <= '0;
            R           <= '0;
            qs          <= '0;
            rem         <= '0;
            ys          <= '0;
            cnt         <= '0;
`ifdef DIVUNS_DIV0_FLAG_EN
            DZ          <= 1'b0;
            dz_pend     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i && in_ready_o) begin
                        ys         <= Y;
                        qs         <= A;
                        rem        <= '0;
                        cnt        <= '0;
                        in_ready_o <= 1'b0;
                        state      <= BUSY;
`ifdef DIVUNS_DIV0_FLAG_EN
                        dz_pend    <= (Y == '0);
`endif
                    end
                end

                BUSY: begin
`ifdef DIVUNS_DIV0_FLAG_EN
                    if (dz_pend) begin
                        // Zero divisor: no iteration, report the saturated result.
                        Q           <= '1;
                        R           <= qs[widthY-1:0];
                        DZ          <= 1'b1;
                        dz_pend     <= 1'b0;
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else
`endif
                    begin
                        qs  <= qs_next;
                        rem <= rem_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST_CNT) begin
                            // Load the result from the final step directly so
                            // out_valid_o rises on the same edge.
                            Q           <= qs_next;
                            R           <= rem_next;
                            out_valid_o <= 1'b1;
                            state       <= DONE;
`ifdef DIVUNS_DIV0_FLAG_EN
                            DZ          <= 1'b0;
`endif
                        end
                    end
                end

                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_uns_seq.sv
// tb/tb_div_uns_seq.sv - directed and randomized self-checking bench for div_uns_seq

module tb_div_uns_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    div_uns_seq #(.widthA(16), .widthY(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .A           (a),
        .Y           (y),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .Q           (q),
        .R           (r)
`ifdef DIVUNS_DIV0_FLAG_EN
        ,
        .DZ          (dz)
`endif
    );

`ifndef DIVUNS_DIV0_FLAG_EN
    assign dz = 1'b0;
`endif

    // Issue one operation with out_ready held high. lat counts cycles
    // including the acceptance cycle (17 for a normal 16-bit divide).
    task automatic run_op(input logic [15:0] ia, input logic [7:0] iy,
                          output logic [15:0] oq, output logic [7:0] orr,
                          output logic odz, output int lat, output bit ok);
        @(negedge clk);
        a = ia; y = iy; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; y = 8'h00;   // operands must not be resampled
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        oq = q; orr = r; odz = dz;
        @(posedge clk); #1;        // output handshake
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (q !== 16'd0) $display("FAIL reset_q got=%0d exp=0", q); else pass_cnt++;
        total_cnt++; if (r !== 8'd0) $display("FAIL reset_r got=%0d exp=0", r); else pass_cnt++;
        total_cnt++; if (dz !== 1'b0) $display("FAIL reset_dz got=%b exp=0", dz); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [15:0] va [6] = '{16'd1000, 16'd65535, 16'd5, 16'd0, 16'd40000, 16'd12345};
        logic [7:0]  vy [6] = '{8'd7,     8'd255,    8'd9,  8'd1,  8'd200,    8'd123};
        logic [15:0] eq [6] = '{16'd142,  16'd257,   16'd0, 16'd0, 16'd200,   16'd100};
        logic [7:0]  er [6] = '{8'd6,     8'd0,      8'd5,  8'd0,  8'd0,      8'd45};
        logic [15:0] gq; logic [7:0] gr; logic gdz; int lat; bit ok;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vy[i], gq, gr, gdz, lat, ok);
            total_cnt++; if (!ok) $display("FAIL basic_timeout vec=%0d got=no out_valid exp=out_valid", i); else pass_cnt++;
            total_cnt++; if (gq !== eq[i]) $display("FAIL basic_q vec=%0d got=%0d exp=%0d", i, gq, eq[i]); else pass_cnt++;
            total_cnt++; if (gr !== er[i]) $display("FAIL basic_r vec=%0d got=%0d exp=%0d", i, gr, er[i]); else pass_cnt++;
            total_cnt++; if (lat !== 17) $display("FAIL basic_latency vec=%0d got=%0d exp=17", i, lat); else pass_cnt++;
            total_cnt++; if (gdz !== 1'b0) $display("FAIL basic_dz vec=%0d got=%b exp=0", i, gdz); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
                $display("FAIL basic_return_idle vec=%0d got in_ready=%b out_valid=%b exp=1/0", i, in_ready, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        @(negedge clk);
        a = 16'd300; y = 8'd16; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'h5555; y = 8'd3;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        total_cnt++; if (!seen) $display("FAIL bp_timeout got=no out_valid exp=out_valid"); else pass_cnt++;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 16'd18 || r !== 8'd12)
                $display("FAIL bp_hold cyc=%0d got v=%b rdy=%b q=%0d r=%0d exp v=1 rdy=0 q=18 r=12",
                         c, out_valid, in_ready, q, r);
            else pass_cnt++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        bit spurious = 1'b0;
        logic [15:0] gq; logic [7:0] gr; logic gdz; int lat; bit ok;
        @(negedge clk);
        a = 16'd1000; y = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;        // accepted, counter = 0
        in_valid = 1'b0;
        repeat (5) @(posedge clk); // counter = 5
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || q !== 16'd0 || r !== 8'd0)
            $display("FAIL midrst_state got rdy=%b v=%b q=%0d r=%0d exp rdy=1 v=0 q=0 r=0", in_ready, out_valid, q, r);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious = 1'b1;
        end
        total_cnt++; if (spurious) $display("FAIL midrst_no_result got=out_valid exp=none"); else pass_cnt++;
        run_op(16'd81, 8'd9, gq, gr, gdz, lat, ok);
        total_cnt++; if (!ok || gq !== 16'd9 || gr !== 8'd0)
            $display("FAIL midrst_next_op got ok=%0d q=%0d r=%0d exp ok=1 q=9 r=0", ok, gq, gr);
        else pass_cnt++;
    endtask

    task automatic test_div0();
        logic [15:0] gq; logic [7:0] gr; logic gdz; int lat; bit ok;
        int exp_lat;
        logic exp_dz;
`ifdef DIVUNS_DIV0_FLAG_EN
        exp_lat = 2;  exp_dz = 1'b1;
`else
        exp_lat = 17; exp_dz = 1'b0;
`endif
        run_op(16'h1234, 8'd0, gq, gr, gdz, lat, ok);
        total_cnt++; if (!ok) $display("FAIL div0_timeout got=no out_valid exp=out_valid"); else pass_cnt++;
        total_cnt++; if (gq !== 16'hFFFF) $display("FAIL div0_q got=%h exp=ffff", gq); else pass_cnt++;
        total_cnt++; if (gr !== 8'h34) $display("FAIL div0_r got=%h exp=34", gr); else pass_cnt++;
        total_cnt++; if (lat !== exp_lat) $display("FAIL div0_latency got=%0d exp=%0d", lat, exp_lat); else pass_cnt++;
        total_cnt++; if (gdz !== exp_dz) $display("FAIL div0_dz got=%b exp=%b", gdz, exp_dz); else pass_cnt++;
        // The flag must clear when the next result is loaded.
        run_op(16'd100, 8'd10, gq, gr, gdz, lat, ok);
        total_cnt++; if (!ok || gq !== 16'd10 || gr !== 8'd0 || gdz !== 1'b0)
            $display("FAIL div0_after got ok=%0d q=%0d r=%0d dz=%b exp ok=1 q=10 r=0 dz=0", ok, gq, gr, gdz);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc_cyc [$];
        int results = 0;
        @(negedge clk);
        a = 16'd1000; y = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_ready) acc_cyc.push_back(c);
            if (out_valid) begin
                results++;
                total_cnt++; if (q !== 16'd142 || r !== 8'd6)
                    $display("FAIL b2b_result cyc=%0d got q=%0d r=%0d exp q=142 r=6", c, q, r);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        total_cnt++; if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] !== 18)
            $display("FAIL b2b_interval got n=%0d gap=%0d exp gap=18", acc_cyc.size(),
                     (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1);
        else pass_cnt++;
        total_cnt++; if (results !== 2) $display("FAIL b2b_count got=%0d exp=2", results); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [7:0]  exp_r [$];
        int n_sent = 0, n_recv = 0, n_bad = 0;
        int target = 250;
        logic [15:0] eq; logic [7:0] er;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int cyc = 0; cyc < 40000 && n_recv < target; cyc++) begin
            @(negedge clk);
            if (!in_valid && n_sent < target && $urandom_range(0, 3) != 0) begin
                a = 16'($urandom_range(0, 65535));
                y = 8'($urandom_range(1, 255));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL rnd_extra got q=%0d r=%0d exp=no result", q, r);
                end else begin
                    eq = exp_q.pop_front(); er = exp_r.pop_front();
                    total_cnt++;
                    if (q !== eq || r !== er)
                        $display("FAIL rnd_result n=%0d got q=%0d r=%0d exp q=%0d r=%0d", n_recv, q, r, eq, er);
                    else pass_cnt++;
                end
                n_recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(a / {8'd0, y});
                exp_r.push_back(8'(a % {8'd0, y}));
                n_sent++;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b1;
        total_cnt++; if (n_recv !== target || n_bad !== 0 || exp_q.size() !== 0)
            $display("FAIL rnd_count got recv=%0d extra=%0d pending=%0d exp recv=%0d extra=0 pending=0",
                     n_recv, n_bad, exp_q.size(), target);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; y = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midop();
        test_div0();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
